charge_controller: RTL and testbench

- Main controller FSM of the coin-operated phone charger.
- Accepts power, coin, confirm and cancel inputs and accumulates inserted money.
- Converts the money into a charging time, counts it down, and signals completion.
- Drives the 3-bit state code consumed by the state-display logic, plus money and remaining-time values for the numeric display.

---
 rtl/charge_controller.sv | 169 ++++++++++++++++
 tb/tb_charge_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/charge_controller.sv
// Main FSM of the coin-operated phone charger: accumulates coins, converts
// money into charge seconds, counts them down and holds a completion state.
module charge_controller #(
  parameter int TICK_DIV     = 100000000,
  parameter int SEC_PER_UNIT = 10,
  parameter int MAX_MONEY    = 20,
  parameter int IDLE_TIMEOUT = 10,
  parameter int DONE_HOLD    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power,
  input  logic       coin1,
  input  logic       coin10,
  input  logic       confirm,
  input  logic       cancel,
  output logic [2:0] state,
  output logic [4:0] money,
  output logic [7:0] remain,
  output logic       reject,
  output logic       refund,
  output logic [4:0] refund_amt
);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SEC_W  = $clog2(IDLE_TIMEOUT + DONE_HOLD + 1);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_READY    = 3'd1,
    ST_INPUT    = 3'd2,
    ST_CHARGING = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t              r_state;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [SEC_W-1:0]    r_sec_cnt;
  logic [4:0]          r_money;
  logic [7:0]          r_remain;
  logic                r_reject;
  logic                r_refund;
  logic [4:0]          r_refund_amt;

  logic                w_tick;
  logic                w_coin;
  logic [5:0]          w_coin_val;
  logic [5:0]          w_sum;
  logic                w_fits;
  logic [SEC_W-1:0]    w_sec_next;

  assign w_tick     = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
  assign w_coin     = coin1 | coin10;
  assign w_coin_val = (coin10 ? 6'd10 : 6'd0) + {5'd0, coin1};
  assign w_sum      = {1'b0, r_money} + w_coin_val;
  assign w_fits     = (w_sum <= 6'(MAX_MONEY));
  assign w_sec_next = r_sec_cnt + SEC_W'(1);

  // FSM with money, countdown, time base and one-cycle pulses; every state
  // change restarts the time base so the first tick is TICK_DIV cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_OFF;
      r_tick_cnt   <= TICK_W'(0);
      r_sec_cnt    <= SEC_W'(0);
      r_money      <= 5'd0;
      r_remain     <= 8'd0;
      r_reject     <= 1'b0;
      r_refund     <= 1'b0;
      r_refund_amt <= 5'd0;
    end else begin
      r_reject     <= 1'b0;
      r_refund     <= 1'b0;
      r_refund_amt <= 5'd0;
      r_tick_cnt   <= w_tick ? TICK_W'(0) : r_tick_cnt + TICK_W'(1);
      r_sec_cnt    <= w_tick ? w_sec_next : r_sec_cnt;
      if (!power) begin
        r_state    <= ST_OFF;
        r_money    <= 5'd0;
        r_remain   <= 8'd0;
        r_reject   <= w_coin;
        r_tick_cnt <= TICK_W'(0);
        r_sec_cnt  <= SEC_W'(0);
      end else begin
        case (r_state)
          ST_OFF: begin
            r_reject   <= w_coin;
            r_state    <= ST_READY;
            r_tick_cnt <= TICK_W'(0);
            r_sec_cnt  <= SEC_W'(0);
          end
          ST_READY: begin
            if (w_coin) begin
              r_state    <= ST_INPUT;
              r_money    <= w_fits ? w_sum[4:0] : 5'(MAX_MONEY);
              r_tick_cnt <= TICK_W'(0);
              r_sec_cnt  <= SEC_W'(0);
            end
          end
          ST_INPUT: begin
            if (cancel) begin
              r_reject     <= w_coin;
              r_refund     <= 1'b1;
              r_refund_amt <= r_money;
              r_money      <= 5'd0;
              r_state      <= ST_READY;
              r_tick_cnt   <= TICK_W'(0);
              r_sec_cnt    <= SEC_W'(0);
            end else if (confirm) begin
              r_reject   <= w_coin;
              r_remain   <= 8'(r_money) * 8'(SEC_PER_UNIT);
              r_state    <= ST_CHARGING;
              r_tick_cnt <= TICK_W'(0);
              r_sec_cnt  <= SEC_W'(0);
            end else if (w_coin && w_fits) begin
              // accepted coin re-arms the idle timeout from scratch
              r_money    <= w_sum[4:0];
              r_tick_cnt <= TICK_W'(0);
              r_sec_cnt  <= SEC_W'(0);
            end else begin
              r_reject <= w_coin;
              if (w_tick && (w_sec_next >= SEC_W'(IDLE_TIMEOUT))) begin
                r_refund     <= 1'b1;
                r_refund_amt <= r_money;
                r_money      <= 5'd0;
                r_state      <= ST_READY;
                r_tick_cnt   <= TICK_W'(0);
                r_sec_cnt    <= SEC_W'(0);
              end
            end
          end
          ST_CHARGING: begin
            r_reject <= w_coin;
            if (cancel || (w_tick && (r_remain <= 8'd1))) begin
              r_remain   <= 8'd0;
              r_money    <= 5'd0;
              r_state    <= ST_DONE;
              r_tick_cnt <= TICK_W'(0);
              r_sec_cnt  <= SEC_W'(0);
            end else if (w_tick) begin
              r_remain <= r_remain - 8'd1;
            end
          end
          ST_DONE: begin
            r_reject <= w_coin;
            if (w_tick && (w_sec_next >= SEC_W'(DONE_HOLD))) begin
              r_state    <= ST_READY;
              r_tick_cnt <= TICK_W'(0);
              r_sec_cnt  <= SEC_W'(0);
            end
          end
          default: begin
            r_state    <= ST_OFF;
            r_money    <= 5'd0;
            r_remain   <= 8'd0;
            r_tick_cnt <= TICK_W'(0);
            r_sec_cnt  <= SEC_W'(0);
          end
        endcase
      end
    end
  end

  assign state      = r_state;
  assign money      = r_money;
  assign remain     = r_remain;
  assign reject     = r_reject;
  assign refund     = r_refund;
  assign refund_amt = r_refund_amt;
endmodule

// File: tb/tb_charge_controller.sv
// Directed plus randomized bench for charge_controller, checked against an
// elapsed-cycle reference model of the charger rules.
module tb_charge_controller;
  localparam int TICK_DIV     = 4;
  localparam int SEC_PER_UNIT = 2;
  localparam int MAX_MONEY    = 20;
  localparam int IDLE_TIMEOUT = 3;
  localparam int DONE_HOLD    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       power = 1'b0;
  logic       coin1 = 1'b0;
  logic       coin10 = 1'b0;
  logic       confirm = 1'b0;
  logic       cancel = 1'b0;
  logic [2:0] state;
  logic [4:0] money;
  logic [7:0] remain;
  logic       reject;
  logic       refund;
  logic [4:0] refund_amt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: elapsed = clock edges since the timer was last armed
  logic [2:0] m_state;
  logic [4:0] m_money;
  logic [7:0] m_remain;
  logic       m_reject;
  logic       m_refund;
  logic [4:0] m_refund_amt;
  int         m_elapsed;

  charge_controller #(
    .TICK_DIV(TICK_DIV), .SEC_PER_UNIT(SEC_PER_UNIT), .MAX_MONEY(MAX_MONEY),
    .IDLE_TIMEOUT(IDLE_TIMEOUT), .DONE_HOLD(DONE_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .power(power), .coin1(coin1), .coin10(coin10),
    .confirm(confirm), .cancel(cancel), .state(state), .money(money),
    .remain(remain), .reject(reject), .refund(refund), .refund_amt(refund_amt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 3'd0; m_money = 5'd0; m_remain = 8'd0;
    m_reject = 1'b0; m_refund = 1'b0; m_refund_amt = 5'd0;
    m_elapsed = 0;
  endtask

  task automatic model_step(input bit pw, input bit c1, input bit c10, input bit cf, input bit cn);
    int  e, val, sum;
    bit  coin, tick, arm;
    e    = m_elapsed + 1;
    tick = (e % TICK_DIV) == 0;
    coin = c1 | c10;
    val  = (c1 ? 1 : 0) + (c10 ? 10 : 0);
    sum  = int'(m_money) + val;
    arm  = 1'b0;
    m_reject = 1'b0; m_refund = 1'b0; m_refund_amt = 5'd0;
    if (!pw) begin
      m_state = 3'd0; m_money = 5'd0; m_remain = 8'd0; m_reject = coin; arm = 1'b1;
    end else begin
      case (m_state)
        3'd0: begin m_reject = coin; m_state = 3'd1; arm = 1'b1; end
        3'd1: if (coin) begin
          m_state = 3'd2; m_money = 5'((val > MAX_MONEY) ? MAX_MONEY : val); arm = 1'b1;
        end
        3'd2: begin
          if (cn) begin
            m_reject = coin; m_refund = 1'b1; m_refund_amt = m_money;
            m_money = 5'd0; m_state = 3'd1; arm = 1'b1;
          end else if (cf) begin
            m_reject = coin; m_remain = 8'(int'(m_money) * SEC_PER_UNIT);
            m_state = 3'd3; arm = 1'b1;
          end else if (coin && sum <= MAX_MONEY) begin
            m_money = 5'(sum); arm = 1'b1;
          end else begin
            m_reject = coin;
            if (e == IDLE_TIMEOUT * TICK_DIV) begin
              m_refund = 1'b1; m_refund_amt = m_money; m_money = 5'd0;
              m_state = 3'd1; arm = 1'b1;
            end
          end
        end
        3'd3: begin
          m_reject = coin;
          if (cn) begin
            m_state = 3'd4; m_money = 5'd0; m_remain = 8'd0; arm = 1'b1;
          end else if (tick) begin
            m_remain = m_remain - 8'd1;
            if (m_remain == 8'd0) begin
              m_state = 3'd4; m_money = 5'd0; arm = 1'b1;
            end
          end
        end
        3'd4: begin
          m_reject = coin;
          if (e == DONE_HOLD * TICK_DIV) begin m_state = 3'd1; arm = 1'b1; end
        end
        default: m_state = 3'd0;
      endcase
    end
    m_elapsed = arm ? 0 : e;
  endtask

  task automatic check_all(input string tag);
    n_checks++;
    assert (state === m_state) else begin
      n_fail++; $error("FAIL %s.state observed=%0d expected=%0d", tag, state, m_state);
    end
    n_checks++;
    assert (money === m_money) else begin
      n_fail++; $error("FAIL %s.money observed=%0d expected=%0d", tag, money, m_money);
    end
    n_checks++;
    assert (remain === m_remain) else begin
      n_fail++; $error("FAIL %s.remain observed=%0d expected=%0d", tag, remain, m_remain);
    end
    n_checks++;
    assert (reject === m_reject) else begin
      n_fail++; $error("FAIL %s.reject observed=%0d expected=%0d", tag, reject, m_reject);
    end
    n_checks++;
    assert (refund === m_refund) else begin
      n_fail++; $error("FAIL %s.refund observed=%0d expected=%0d", tag, refund, m_refund);
    end
    n_checks++;
    assert (refund_amt === m_refund_amt) else begin
      n_fail++; $error("FAIL %s.refund_amt observed=%0d expected=%0d", tag, refund_amt, m_refund_amt);
    end
  endtask

  task automatic expect_val(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit pw, input bit c1, input bit c10,
                       input bit cf, input bit cn, input string tag);
    rst = r; power = pw; coin1 = c1; coin10 = c10; confirm = cf; cancel = cn;
    @(posedge clk);
    if (r) model_reset();
    else model_step(pw, c1, c10, cf, cn);
    #1;
    check_all(tag);
  endtask

  task automatic step(input bit c1, input bit c10, input bit cf, input bit cn, input string tag);
    cycle(1'b0, 1'b1, c1, c10, cf, cn, tag);
  endtask

  initial begin
    int n;
    model_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset0");
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "reset1");
    expect_val("reset_state", int'(state), 0);

    step(1'b0, 1'b0, 1'b0, 1'b0, "power_on");
    expect_val("power_on_state", int'(state), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, "first_coin1");
    expect_val("first_coin_money", int'(money), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, "coin10");
    expect_val("money_11", int'(money), 11);
    step(1'b0, 1'b1, 1'b0, 1'b0, "coin10_over");
    expect_val("over_reject", int'(reject), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, "reject_clear");
    step(1'b0, 1'b0, 1'b0, 1'b1, "cancel_11");

    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "build9");
    step(1'b1, 1'b1, 1'b0, 1'b0, "both_coins");
    expect_val("money_20", int'(money), 20);
    expect_val("both_no_reject", int'(reject), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, "cancel_20");

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "build3");
    step(1'b0, 1'b0, 1'b1, 1'b0, "confirm3");
    expect_val("charge_remain", int'(remain), 6);
    n = 0;
    while (state != 3'd4 && n < 40) begin step(1'b0, 1'b0, 1'b0, 1'b0, "charging"); n++; end
    expect_val("charge_cycles", n, 24);
    n = 0;
    while (state != 3'd1 && n < 20) begin step(1'b0, 1'b0, 1'b0, 1'b0, "done_hold"); n++; end
    expect_val("done_cycles", n, 8);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "build5");
    step(1'b1, 1'b0, 1'b1, 1'b1, "cancel_confirm_coin");
    expect_val("cc_state", int'(state), 1);
    expect_val("cc_refund_amt", int'(refund_amt), 5);
    expect_val("cc_reject", int'(reject), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, "refund_clear");
    expect_val("refund_pulse", int'(refund), 0);

    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "build2");
    n = 0;
    while (state != 3'd1 && n < 30) begin step(1'b0, 1'b0, 1'b0, 1'b0, "idle"); n++; end
    expect_val("idle_cycles", n, 12);
    expect_val("idle_refund_amt", int'(refund_amt), 2);

    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "build2b");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "idle_pre");
    step(1'b1, 1'b0, 1'b0, 1'b0, "rearm_coin");
    n = 0;
    while (state != 3'd1 && n < 30) begin step(1'b0, 1'b0, 1'b0, 1'b0, "idle_re"); n++; end
    expect_val("rearm_cycles", n, 12);

    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "build2c");
    step(1'b0, 1'b0, 1'b1, 1'b0, "confirm2");
    expect_val("remain_4", int'(remain), 4);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "power_drop");
    expect_val("drop_state", int'(state), 0);
    expect_val("drop_remain", int'(remain), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, "repower");

    step(1'b1, 1'b0, 1'b0, 1'b0, "build1");
    step(1'b0, 1'b0, 1'b1, 1'b0, "confirm1");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "mid_charge");
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_mid");
    expect_val("rst_mid_state", int'(state), 0);
    expect_val("rst_mid_reject", int'(reject), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 63) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 47) == 0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
